// File: rtl/i2s_tx_master.sv
// I2S master transmitter: stereo samples from a small FIFO serialised into 64-SCK Philips frames.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating 16-bit underrun_cnt_o output.
module i2s_tx_master #(
    parameter int CLK_DIV    = 2,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_left,
    input  logic [DATA_W-1:0]           s_right,
    output logic                        i2s_sck,
    output logic                        i2s_ws,
    output logic                        i2s_sd,
    output logic                        frame_start_o,
    output logic                        underrun_o,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    output logic [15:0]                 underrun_cnt_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PAD  = 32 - DATA_W;
    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
    localparam logic [5:0]      SLOT_IDLE = 6'd62;

    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wrPtr_q, rdPtr_q;
    logic [LW-1:0]       level_q, level_d;
    logic                readyEn_q;
    logic                full, empty, push, pop;

    logic [DIVW-1:0]     divCnt_q, divCnt_d;
    logic [5:0]          slot_q, slot_d, slotInc;
    logic                sck_q, sck_d, ws_q, ws_d, sd_q, sd_d;
    logic [DATA_W-1:0]   shadowL_q, shadowL_d, shadowR_q, shadowR_d;
    logic                frameStart_d, frameStart_q, underrun_d, underrun_q;
    logic                tick, fall;
    logic [31:0]         chWord;
    logic [4:0]          bitIdx;

    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign s_ready = readyEn_q & ~full;
    assign push    = s_valid & s_ready;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= {s_left, s_right};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            level_q   <= '0;
            readyEn_q <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
            level_q   <= level_d;
            if (push) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
        end
    end

    // Samples are left-aligned in a 32-bit slot so the bit index is simply 31 - slot position.
    assign tick    = (divCnt_q == DIV_LAST);
    assign fall    = en & tick & sck_q;
    assign slotInc = slot_q + 6'd1;
    assign chWord  = slotInc[5] ? {shadowR_q, {PAD{1'b0}}} : {shadowL_q, {PAD{1'b0}}};
    assign bitIdx  = 5'd31 - slotInc[4:0];

    always_comb begin
        divCnt_d     = divCnt_q;
        slot_d       = slot_q;
        sck_d        = sck_q;
        ws_d         = ws_q;
        sd_d         = sd_q;
        shadowL_d    = shadowL_q;
        shadowR_d    = shadowR_q;
        frameStart_d = 1'b0;
        underrun_d   = 1'b0;
        pop          = 1'b0;
        if (!en) begin
            divCnt_d  = '0;
            slot_d    = SLOT_IDLE;
            sck_d     = 1'b0;
            ws_d      = 1'b1;
            sd_d      = 1'b0;
            shadowL_d = '0;
            shadowR_d = '0;
        end else begin
            divCnt_d = tick ? '0 : divCnt_q + DIVW'(1);
            if (tick) sck_d = ~sck_q;
            if (fall) begin
                slot_d = slotInc;
                ws_d   = (slotInc >= 6'd31) && (slotInc <= 6'd62);
                sd_d   = chWord[bitIdx];
                // Entering slot 63 loads the next pair; an empty FIFO sends silence.
                if (slotInc == 6'd63) begin
                    frameStart_d = 1'b1;
                    if (empty) begin
                        underrun_d = 1'b1;
                        shadowL_d  = '0;
                        shadowR_d  = '0;
                    end else begin
                        pop                    = 1'b1;
                        {shadowL_d, shadowR_d} = mem_q[rdPtr_q];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt_q     <= '0;
            slot_q       <= SLOT_IDLE;
            sck_q        <= 1'b0;
            ws_q         <= 1'b1;
            sd_q         <= 1'b0;
            shadowL_q    <= '0;
            shadowR_q    <= '0;
            frameStart_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            divCnt_q     <= divCnt_d;
            slot_q       <= slot_d;
            sck_q        <= sck_d;
            ws_q         <= ws_d;
            sd_q         <= sd_d;
            shadowL_q    <= shadowL_d;
            shadowR_q    <= shadowR_d;
            frameStart_q <= frameStart_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] urCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  urCnt_q <= '0;
        else if (underrun_d && urCnt_q != 16'hFFFF) urCnt_q <= urCnt_q + 16'd1;
    end

    assign underrun_cnt_o = urCnt_q;
`endif

    assign i2s_sck       = sck_q;
    assign i2s_ws        = ws_q;
    assign i2s_sd        = sd_q;
    assign frame_start_o = frameStart_q;
    assign underrun_o    = underrun_q;
    assign fifo_level_o  = level_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed bench for i2s_tx_master: a CLK_DIV=2 instance for the main tests and a CLK_DIV=1 instance for the fast-clock frame.
module tb_i2s_tx_master;

    typedef struct {
        logic [23:0] pushL;
        logic [23:0] pushR;
        bit          doPush;
        logic [23:0] expL;
        logic [23:0] expR;
        bit          expUnder;
    } frameVec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic valid = 1'b0;
    logic sel   = 1'b0;
    logic [23:0] left  = '0;
    logic [23:0] right = '0;

    logic enA, enB, validA, validB;
    logic readyA, sckA, wsA, sdA, fsA, urA;
    logic readyB, sckB, wsB, sdB, fsB, urB;
    logic [2:0] lvlA, lvlB;
    logic rdy, sck, ws, sd, fs, ur;
    logic [2:0] lvl;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] cntA, cntB, cnt;
    assign cnt = sel ? cntB : cntA;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mslot  = 62;
    logic prevSck = 1'b0;
    logic fell    = 1'b0;

    always #5 clk = ~clk;

    assign enA    = en & ~sel;
    assign enB    = en & sel;
    assign validA = valid & ~sel;
    assign validB = valid & sel;
    assign rdy = sel ? readyB : readyA;
    assign sck = sel ? sckB : sckA;
    assign ws  = sel ? wsB : wsA;
    assign sd  = sel ? sdB : sdA;
    assign fs  = sel ? fsB : fsA;
    assign ur  = sel ? urB : urA;
    assign lvl = sel ? lvlB : lvlA;

    i2s_tx_master #(.CLK_DIV(2), .DATA_W(24), .FIFO_DEPTH(4)) dutA (
        .clk(clk), .rst_n(rst_n), .en(enA), .s_valid(validA), .s_ready(readyA),
        .s_left(left), .s_right(right), .i2s_sck(sckA), .i2s_ws(wsA), .i2s_sd(sdA),
        .frame_start_o(fsA), .underrun_o(urA),
`ifdef I2S_TX_UNDERRUN_CNT_EN
        .underrun_cnt_o(cntA),
`endif
        .fifo_level_o(lvlA)
    );

    i2s_tx_master #(.CLK_DIV(1), .DATA_W(24), .FIFO_DEPTH(4)) dutB (
        .clk(clk), .rst_n(rst_n), .en(enB), .s_valid(validB), .s_ready(readyB),
        .s_left(left), .s_right(right), .i2s_sck(sckB), .i2s_ws(wsB), .i2s_sd(sdB),
        .frame_start_o(fsB), .underrun_o(urB),
`ifdef I2S_TX_UNDERRUN_CNT_EN
        .underrun_cnt_o(cntB),
`endif
        .fifo_level_o(lvlB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [23:0] l, input logic [23:0] r);
        en    = e;
        valid = v;
        left  = l;
        right = r;
    endtask

    // The bench keeps its own slot count, advanced on every observed SCK fall while enabled.
    task automatic stepClk();
        @(negedge clk);
        cyc++;
        fell    = prevSck & ~sck & en;
        prevSck = sck;
        if (fell) mslot = (mslot + 1) % 64;
    endtask

    task automatic waitSlot(input int target, output int took, output bit ok);
        took = 0;
        ok   = 1'b0;
        while (!ok && took < 600) begin
            stepClk();
            took++;
            ok = fell && (mslot == target);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitSlot actual=timeout expected=slot %0d", target);
        end
    endtask

    task automatic captureFrame(output logic [31:0] lw, output logic [31:0] rw, output int wsBad);
        int took;
        bit ok;
        lw    = '0;
        rw    = '0;
        wsBad = 0;
        for (int s = 0; s < 63; s++) begin
            waitSlot(s, took, ok);
            if (!ok) break;
            if (s < 32) lw[31-s] = sd;
            else        rw[63-s] = sd;
            if (ws !== ((s >= 31) ? 1'b1 : 1'b0)) wsBad++;
        end
    endtask

    task automatic checkLoad(input string name, input logic expUr);
        checkOutput({name, " frame_start"}, 32'(fs), 32'd1);
        checkOutput({name, " underrun"}, 32'(ur), 32'(expUr));
        checkOutput({name, " ws slot63"}, 32'(ws), 32'd0);
        checkOutput({name, " sd slot63"}, 32'(sd), 32'd0);
    endtask

    initial begin
        frameVec_t vecs[6];
        logic [31:0] lw, rw;
        int wsBad, took, k, accepted, t0, expCnt;
        bit ok;
        logic rb;

        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 1'b1, 24'hA5A5A5, 24'h5A5A5A, 1'b0};
        vecs[1] = '{24'h800000, 24'h000001, 1'b1, 24'h800000, 24'h000001, 1'b0};
        vecs[2] = '{24'h000000, 24'h000000, 1'b0, 24'h000000, 24'h000000, 1'b1};
        vecs[3] = '{24'h000000, 24'h000000, 1'b0, 24'h000000, 24'h000000, 1'b1};
        vecs[4] = '{24'hFFFFFF, 24'h7FFFFF, 1'b1, 24'hFFFFFF, 24'h7FFFFF, 1'b0};
        vecs[5] = '{24'h123456, 24'hABCDEF, 1'b1, 24'h123456, 24'hABCDEF, 1'b0};
        expCnt = 0;

        // Reset values while rst_n is held low.
        stepClk();
        checkOutput("reset sck", 32'(sck), 32'd0);
        checkOutput("reset ws", 32'(ws), 32'd1);
        checkOutput("reset sd", 32'(sd), 32'd0);
        checkOutput("reset ready", 32'(rdy), 32'd0);
        checkOutput("reset frame_start", 32'(fs), 32'd0);
        checkOutput("reset underrun", 32'(ur), 32'd0);
        checkOutput("reset level", 32'(lvl), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        checkOutput("reset underrun_cnt", 32'(cnt), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        checkOutput("ready before first clk", 32'(rdy), 32'd0);
        stepClk();
        checkOutput("ready after release", 32'(rdy), 32'd1);

        // Startup: one pair queued, then enable.
        applyStimulus(1'b0, 1'b1, vecs[0].pushL, vecs[0].pushR);
        stepClk();
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("level after push", 32'(lvl), 32'd1);
        waitSlot(63, took, ok);
        checkOutput("first fall latency", 32'(took), 32'd4);
        checkLoad("startup", 1'b0);

        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                if (vecs[i].doPush) begin
                    applyStimulus(1'b1, 1'b1, vecs[i].pushL, vecs[i].pushR);
                    stepClk();
                    applyStimulus(1'b1, 1'b0, '0, '0);
                end
                waitSlot(63, took, ok);
                checkLoad($sformatf("vec%0d", i), vecs[i].expUnder);
            end
            captureFrame(lw, rw, wsBad);
            checkOutput($sformatf("vec%0d left", i), lw, {vecs[i].expL, 8'h00});
            checkOutput($sformatf("vec%0d right", i), rw, {vecs[i].expR, 8'h00});
            checkOutput($sformatf("vec%0d ws errors", i), 32'(wsBad), 32'd0);
            if (vecs[i].expUnder) expCnt++;
`ifdef I2S_TX_UNDERRUN_CNT_EN
            checkOutput($sformatf("vec%0d underrun_cnt", i), 32'(cnt), 32'(expCnt));
`endif
        end
        applyStimulus(1'b0, 1'b0, '0, '0);
        mslot = 62;
        stepClk();

        // Fill the FIFO with en low: only FIFO_DEPTH pushes may be accepted.
        k = 1;
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b1, 24'(k), 24'h800000 | 24'(k));
            rb = rdy;
            stepClk();
            if (rb) begin
                accepted++;
                k++;
            end
        end
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("fill accepted", 32'(accepted), 32'd4);
        checkOutput("fill ready", 32'(rdy), 32'd0);
        checkOutput("fill level", 32'(lvl), 32'd4);
        waitSlot(63, took, ok);
        checkOutput("fill first fall latency", 32'(took), 32'd4);
        checkOutput("ready after first pop", 32'(rdy), 32'd1);
        checkOutput("level after first pop", 32'(lvl), 32'd3);
        for (int j = 1; j <= 4; j++) begin
            if (j > 1) begin
                waitSlot(63, took, ok);
                checkLoad($sformatf("order%0d", j), 1'b0);
            end
            captureFrame(lw, rw, wsBad);
            checkOutput($sformatf("order%0d left", j), lw, {24'(j), 8'h00});
            checkOutput($sformatf("order%0d right", j), rw, {24'h800000 | 24'(j), 8'h00});
        end

        // Drop en in slot 10 of a frame, leaving two pairs queued behind it.
        applyStimulus(1'b1, 1'b1, 24'hC0FFEE, 24'h000000);
        stepClk();
        applyStimulus(1'b1, 1'b1, 24'h5EED01, 24'h0BEEF0);
        stepClk();
        applyStimulus(1'b1, 1'b1, 24'h777777, 24'hFFFFFF);
        stepClk();
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitSlot(63, took, ok);
        checkLoad("drop load", 1'b0);
        checkOutput("drop level at load", 32'(lvl), 32'd2);
        waitSlot(10, took, ok);
        stepClk();
        stepClk();
        checkOutput("slot10 sck high", 32'(sck), 32'd1);
        checkOutput("slot10 sd", 32'(sd), 32'd1);
        checkOutput("slot10 ws", 32'(ws), 32'd0);
        applyStimulus(1'b0, 1'b0, '0, '0);
        mslot = 62;
        stepClk();
        checkOutput("drop sck", 32'(sck), 32'd0);
        checkOutput("drop ws", 32'(ws), 32'd1);
        checkOutput("drop sd", 32'(sd), 32'd0);
        checkOutput("drop level", 32'(lvl), 32'd2);
        checkOutput("drop underrun", 32'(ur), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitSlot(63, took, ok);
        checkOutput("reenable latency", 32'(took), 32'd4);
        checkLoad("reenable", 1'b0);
        checkOutput("reenable level", 32'(lvl), 32'd1);
        captureFrame(lw, rw, wsBad);
        checkOutput("reenable left", lw, {24'h5EED01, 8'h00});
        checkOutput("reenable right", rw, {24'h0BEEF0, 8'h00});

        // Asynchronous reset in slot 40 while SCK is high.
        applyStimulus(1'b1, 1'b1, 24'h111111, 24'h222222);
        stepClk();
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitSlot(63, took, ok);
        checkOutput("pre-reset level", 32'(lvl), 32'd1);
        waitSlot(40, took, ok);
        stepClk();
        stepClk();
        checkOutput("slot40 sck high", 32'(sck), 32'd1);
        checkOutput("slot40 sd", 32'(sd), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset sck", 32'(sck), 32'd0);
        checkOutput("async reset ws", 32'(ws), 32'd1);
        checkOutput("async reset sd", 32'(sd), 32'd0);
        checkOutput("async reset level", 32'(lvl), 32'd0);
        checkOutput("async reset ready", 32'(rdy), 32'd0);
        applyStimulus(1'b0, 1'b0, '0, '0);
        prevSck = 1'b0;
        mslot   = 62;
        stepClk();
        checkOutput("ready held in reset", 32'(rdy), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready at release", 32'(rdy), 32'd0);
        stepClk();
        checkOutput("ready after re-release", 32'(rdy), 32'd1);
        checkOutput("level after re-release", 32'(lvl), 32'd0);

        // CLK_DIV=1 instance: same bit pattern, 128-clk frames.
        sel = 1'b1;
        prevSck = 1'b0;
        mslot   = 62;
        applyStimulus(1'b0, 1'b1, 24'hA5A5A5, 24'h5A5A5A);
        stepClk();
        applyStimulus(1'b1, 1'b0, '0, '0);
        waitSlot(63, took, ok);
        checkOutput("div1 first fall latency", 32'(took), 32'd2);
        checkLoad("div1", 1'b0);
        t0 = cyc;
        captureFrame(lw, rw, wsBad);
        checkOutput("div1 left", lw, 32'hA5A5A500);
        checkOutput("div1 right", rw, 32'h5A5A5A00);
        checkOutput("div1 ws errors", 32'(wsBad), 32'd0);
        waitSlot(63, took, ok);
        checkOutput("div1 frame length", 32'(cyc - t0), 32'd128);
        checkOutput("div1 underrun", 32'(ur), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, '0);
        stepClk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx_master.md
Name: i2s_tx_master

Overview:
- I2S master transmitter. Takes stereo 24-bit samples from user logic through a valid/ready stream and serialises them to an I2S DAC/amplifier in a 64-SCK frame: 32 slots per channel, Philips alignment, MSB first.
- FPGA generates SCK and WS. The frame format matches the microphone receive path, so a loopback via the receive driver works.
- A small sample FIFO absorbs jitter between the processing pipeline and the audio frame rate.

Parameters:
- CLK_DIV, 2, SCK half-period in clk cycles (>=1). SCK = clk/(2*CLK_DIV).
- DATA_W, 24, sample width (<=31).
- FIFO_DEPTH, 4, stereo-pair FIFO depth; power of 2, >=2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- en  in  1  transmitter enable
- s_valid  in  1  sample pair valid
- s_ready  out  1  FIFO can accept a pair
- s_left  in  DATA_W  left sample (two's complement)
- s_right  in  DATA_W  right sample
- i2s_sck  out  1  serial clock to DAC
- i2s_ws  out  1  word select: 0 = left, 1 = right
- i2s_sd  out  1  serial data
- frame_start_o  out  1  1-clk pulse when a pair is loaded for transmission
- underrun_o  out  1  1-clk pulse when a load finds the FIFO empty
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: rst_n is asynchronous, active-low. All state is cleared and outputs take these values:
  - i2s_sck=0, i2s_ws=1, i2s_sd=0
  - s_ready=0 while rst_n is low; 1 from the first clk after release
  - frame_start_o=0, underrun_o=0, fifo_level_o=0
  - slot counter = 62 (idle value), shadow L/R registers = 0
- FIFO:
  - Push when s_valid & s_ready at posedge clk.
  - s_ready = !full, computed from registered occupancy. No push when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop (not full, not empty): level unchanged.
  - FIFO contents persist across en toggles.
- SCK generation:
  - Only while en=1: a divider counts 0..CLK_DIV-1 and i2s_sck toggles on wrap.
  - The first toggle after en rises is low->high.
  - i2s_sck, i2s_ws and i2s_sd are all registered in clk. The "falling-edge event" is the clk cycle in which i2s_sck goes 1->0.
- Slot counter:
  - Range 0..63, incremented (wrapping 63->0) at each falling-edge event.
  - i2s_ws and i2s_sd are updated in the same cycle as the counter, i.e. aligned to the SCK falling edge, stable across the rising edge.
- WS per slot s: 0 for s in 63 and 0..30; 1 for s in 31..62. WS therefore leads the MSB by one SCK.
- SD per slot:
  - s=0..DATA_W-1: left[DATA_W-1-s]
  - s=32..32+DATA_W-1: right[DATA_W-1-(s-32)]
  - all other slots: 0
- Load:
  - On the falling-edge event entering slot 63: if the FIFO is non-empty, pop into the shadow L/R registers and pulse frame_start_o.
  - If the FIFO is empty, load L=R=0 and pulse underrun_o (frame_start_o also pulses).
- Startup: en rising from idle gives the first falling-edge event 2*CLK_DIV clk cycles later. That event enters slot 63 and performs a load. The left MSB follows one SCK period later.
- en deassertion:
  - Takes effect at the next clk, mid-frame included.
  - i2s_sck forced 0, i2s_ws 1, i2s_sd 0.
  - Divider and slot counter return to idle values; the shadow pair is discarded.
  - No underrun is reported while en=0.
- Reset mid-frame: outputs return to reset values immediately and asynchronously, and the FIFO is emptied.
- Frame rate: one pair consumed per 128*CLK_DIV clk cycles.

Optional Feature:
- Macro I2S_TX_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt_o, 16 bits. It is a saturating count of underrun events, holds at 0xFFFF, and is cleared only by rst_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- CLK_DIV=2. Push L=0xA5A5A5, R=0x5A5A5A, then en=1:
  - first falling edge at clk 4 after en, with frame_start_o pulsing;
  - SD slots 0..23 = 0xA5A5A5 MSB first, slots 24..31 = 0;
  - slots 32..55 = 0x5A5A5A;
  - WS low in slots 63,0..30 and high in 31..62;
  - no underrun.
- en=1 with an empty FIFO: underrun_o pulses at each slot-63 load, SD stays 0 for the whole frame. With the macro defined, underrun_cnt_o increments 0->1->2.
- Hold s_valid=1 with en=0 and FIFO_DEPTH=4: exactly 4 pushes accepted, s_ready=0, fifo_level_o=4. Then en=1: s_ready rises the clk after the first pop; order is preserved (pushes 0x000001..0x000004 appear in order).
- Drop en in slot 10: next clk i2s_sck=0, ws=1, sd=0. Re-enable: a new load occurs at the first falling edge, with the remaining FIFO pairs intact.
- Assert rst_n=0 mid-frame in slot 40: outputs return to reset values asynchronously (before the next clk edge); fifo_level_o=0; s_ready=0 until the first clk after release.
- CLK_DIV=1: SCK = clk/2, and the first test's bit pattern is reproduced with 128-clk frames.
